// File: rtl/multi_key_click_module.sv
// Multi-channel key debouncer with single/double/long click detection.
// Optional build macro REPEAT_EN enables long-press auto-repeat pulses.
module multi_key_click_module #(
   parameter int KEY_NUM      = 4,
   parameter int DEBOUNCE_CYC = 500000,
   parameter int LONG_CYC     = 50000000,
   parameter int GAP_CYC      = 15000000,
   parameter int REPEAT_CYC   = 10000000
) (
   input  logic               CLOCK,
   input  logic               RST,
   input  logic [KEY_NUM-1:0] KEY,
   output logic [KEY_NUM-1:0] KEY_LVL,
   output logic [KEY_NUM-1:0] SCLICK,
   output logic [KEY_NUM-1:0] LCLICK,
   output logic [KEY_NUM-1:0] DCLICK
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
   localparam int HOLD_W = $clog2(LONG_CYC + 1);
   localparam int GAP_W  = $clog2(GAP_CYC + 1);

   // Terminal values: the event fires on the edge where the count would reach its parameter.
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

`ifdef REPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_CYC + 1);
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYC - 1);
`endif

   if (KEY_NUM < 1 || KEY_NUM > 16 || DEBOUNCE_CYC < 1 || LONG_CYC < 1 ||
       GAP_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_param
      $error("multi_key_click_module: parameter out of range");
   end

   typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;

   for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
      logic              sync1, sync2, lvl;
      logic [DB_W-1:0]   db_cnt;
      state_t            state, state_nxt;
      logic [HOLD_W-1:0] hold, hold_nxt;
      logic [GAP_W-1:0]  gap, gap_nxt;
      logic              sclick, lclick, dclick;
      logic              sclick_nxt, lclick_nxt, dclick_nxt;
`ifdef REPEAT_EN
      logic [RPT_W-1:0]  rpt, rpt_nxt;
`endif

      // Key is active-low; synchronise the pressed level so reset means released.
      always_ff @(posedge CLOCK) begin
         if (RST) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            lvl    <= 1'b0;
            db_cnt <= '0;
         end else begin
            sync1 <= ~KEY[i];
            sync2 <= sync1;
            if (sync2 == lvl) begin
               db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
               lvl    <= sync2;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + DB_W'(1);
            end
         end
      end

      always_comb begin
         state_nxt  = state;
         hold_nxt   = hold;
         gap_nxt    = gap;
         sclick_nxt = 1'b0;
         lclick_nxt = 1'b0;
         dclick_nxt = 1'b0;
`ifdef REPEAT_EN
         rpt_nxt    = rpt;
`endif
         case (state)
            IDLE: begin
               if (lvl) begin
                  state_nxt = PRESS1;
                  hold_nxt  = '0;
               end
            end
            PRESS1: begin
               if (!lvl) begin
                  state_nxt = WAIT2;
                  gap_nxt   = '0;
               end else if (hold == HOLD_LAST) begin
                  state_nxt  = LONG;
                  lclick_nxt = 1'b1;
`ifdef REPEAT_EN
                  rpt_nxt    = '0;
`endif
               end else begin
                  hold_nxt = hold + HOLD_W'(1);
               end
            end
            WAIT2: begin
               if (lvl) begin
                  state_nxt  = PRESS2;
                  dclick_nxt = 1'b1;
               end else if (gap == GAP_LAST) begin
                  state_nxt  = IDLE;
                  sclick_nxt = 1'b1;
               end else begin
                  gap_nxt = gap + GAP_W'(1);
               end
            end
            PRESS2: begin
               if (!lvl) state_nxt = IDLE;
            end
            LONG: begin
               if (!lvl) begin
                  state_nxt = IDLE;
`ifdef REPEAT_EN
               end else if (rpt == RPT_LAST) begin
                  lclick_nxt = 1'b1;
                  rpt_nxt    = '0;
               end else begin
                  rpt_nxt = rpt + RPT_W'(1);
`endif
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

      always_ff @(posedge CLOCK) begin
         if (RST) begin
            state  <= IDLE;
            hold   <= '0;
            gap    <= '0;
            sclick <= 1'b0;
            lclick <= 1'b0;
            dclick <= 1'b0;
`ifdef REPEAT_EN
            rpt    <= '0;
`endif
         end else begin
            state  <= state_nxt;
            hold   <= hold_nxt;
            gap    <= gap_nxt;
            sclick <= sclick_nxt;
            lclick <= lclick_nxt;
            dclick <= dclick_nxt;
`ifdef REPEAT_EN
            rpt    <= rpt_nxt;
`endif
         end
      end

      assign KEY_LVL[i] = lvl;
      assign SCLICK[i]  = sclick;
      assign LCLICK[i]  = lclick;
      assign DCLICK[i]  = dclick;
   end

endmodule

// File: tb/tb_multi_key_click_module.sv
// Directed bench for multi_key_click_module; expected pulses are scheduled in a
// queue by absolute cycle and matched against every pulse the DUT emits.
module tb_multi_key_click_module;

   localparam int DEB   = 4;
   localparam int LONGC = 20;
   localparam int GAPC  = 10;
   localparam int RPTC  = 8;
   localparam int LAT   = 2 + DEB;

   logic       CLOCK = 1'b0;
   logic       RST;
   logic [3:0] KEY;
   logic [3:0] KEY_LVL, SCLICK, LCLICK, DCLICK;

   multi_key_click_module #(
      .KEY_NUM(4), .DEBOUNCE_CYC(DEB), .LONG_CYC(LONGC),
      .GAP_CYC(GAPC), .REPEAT_CYC(RPTC)
   ) dut (
      .CLOCK(CLOCK), .RST(RST), .KEY(KEY), .KEY_LVL(KEY_LVL),
      .SCLICK(SCLICK), .LCLICK(LCLICK), .DCLICK(DCLICK)
   );

   always #5 CLOCK = ~CLOCK;

   int cyc = 0;
   always @(posedge CLOCK) cyc <= cyc + 1;

   typedef struct {int cyc; int ch; int kind;} ev_t;
   ev_t exp_q[$];
   int  checks = 0;
   int  passed = 0;
   bit  mon_en = 1'b0;
   string kind_name[3] = '{"SCLICK", "LCLICK", "DCLICK"};

   function automatic void push(int c, int ch, int kind);
      ev_t e;
      e.cyc = c; e.ch = ch; e.kind = kind;
      exp_q.push_back(e);
   endfunction

   function automatic void push_long(int ch, int rise, int fall);
      push(rise + LONGC + 1, ch, 1);
`ifdef REPEAT_EN
      for (int t = rise + LONGC + 1 + RPTC; t <= fall; t += RPTC) push(t, ch, 1);
`endif
   endfunction

   task automatic chk(string tag, logic [3:0] obs, logic [3:0] expv);
      checks++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
   endtask

   task automatic step(int n);
      repeat (n) @(negedge CLOCK);
   endtask

   // Pulse scoreboard: any asserted pulse, or any pulse due this cycle, is compared.
   always @(negedge CLOCK) begin
      if (mon_en) begin
         logic [3:0] vec;
         logic       e;
         for (int k = 0; k < 3; k++) begin
            vec = (k == 0) ? SCLICK : (k == 1) ? LCLICK : DCLICK;
            for (int ch = 0; ch < 4; ch++) begin
               e = 1'b0;
               foreach (exp_q[j])
                  if (exp_q[j].cyc == cyc && exp_q[j].ch == ch && exp_q[j].kind == k) e = 1'b1;
               if (vec[ch] !== 1'b0 || e) begin
                  checks++;
                  assert (vec[ch] === e) passed++;
                  else $error("FAIL %s[%0d] cycle %0d: observed %b expected %b",
                              kind_name[k], ch, cyc, vec[ch], e);
               end
            end
         end
         for (int j = exp_q.size() - 1; j >= 0; j--)
            if (exp_q[j].cyc <= cyc) exp_q.delete(j);
      end
   end

   initial begin
      int c, r, f, d;
      KEY = '1;
      RST = 1'b1;
      step(3);
      chk("reset KEY_LVL", KEY_LVL, 4'b0000);
      chk("reset SCLICK", SCLICK, 4'b0000);
      chk("reset LCLICK", LCLICK, 4'b0000);
      chk("reset DCLICK", DCLICK, 4'b0000);
      RST = 1'b0;
      mon_en = 1'b1;
      step(2);

      // single click on key 0
      c = cyc; KEY[0] = 1'b0; r = c + LAT;
      step(LAT - 1);
      chk("debounce before rise", KEY_LVL, 4'b0000);
      step(1);
      chk("debounce rise", KEY_LVL, 4'b0001);
      step(10 - LAT);
      KEY[0] = 1'b1; f = cyc + LAT;
      push(f + GAPC + 1, 0, 0);
      step(LAT);
      chk("debounce fall", KEY_LVL, 4'b0000);
      step(GAPC + 6);

      // 3-cycle glitch on key 1
      KEY[1] = 1'b0;
      step(3);
      KEY[1] = 1'b1;
      step(LAT + 2);
      chk("glitch KEY_LVL", KEY_LVL, 4'b0000);
      step(GAPC + LONGC);

      // double click on key 2
      KEY[2] = 1'b0;
      step(8);
      KEY[2] = 1'b1;
      step(6);
      c = cyc; KEY[2] = 1'b0;
      push(c + LAT + 1, 2, 2);
      step(8);
      KEY[2] = 1'b1;
      step(LAT + GAPC + 5);

      // long press on key 3
      c = cyc; KEY[3] = 1'b0;
      push_long(3, c + LAT, c + 40 + LAT);
      step(40);
      KEY[3] = 1'b1;
      step(LAT + GAPC + 5);

      // simultaneous short presses on keys 0 and 3
      KEY[0] = 1'b0; KEY[3] = 1'b0;
      step(8);
      chk("dual press KEY_LVL", KEY_LVL, 4'b1001);
      KEY[0] = 1'b1; KEY[3] = 1'b1;
      f = cyc + LAT;
      push(f + GAPC + 1, 0, 0);
      push(f + GAPC + 1, 3, 0);
      step(LAT + GAPC + 5);

      // reset in the middle of a press on key 1, key still held
      c = cyc; KEY[1] = 1'b0; r = c + LAT;
      step(LAT + 5);
      chk("press1 KEY_LVL", KEY_LVL, 4'b0010);
      RST = 1'b1;
      step(1);
      chk("mid-press reset KEY_LVL", KEY_LVL, 4'b0000);
      chk("mid-press reset SCLICK", SCLICK, 4'b0000);
      chk("mid-press reset LCLICK", LCLICK, 4'b0000);
      chk("mid-press reset DCLICK", DCLICK, 4'b0000);
      RST = 1'b0;
      d = cyc;
      push_long(1, d + LAT, d + 40 + LAT);
      step(LAT - 1);
      chk("re-debounce before rise", KEY_LVL, 4'b0000);
      step(1);
      chk("re-debounce rise", KEY_LVL, 4'b0010);
      step(40 - LAT);
      KEY[1] = 1'b1;
      step(LAT + GAPC + 5);

      checks++;
      assert (exp_q.size() == 0) passed++;
      else $error("FAIL leftover expected pulses: observed %0d pending expected 0", exp_q.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/multi_key_click_module.md
MULTI_KEY_CLICK_MODULE -- requirements
Module: multi_key_click_module

Interface
REQ-001 Parameter KEY_NUM, 4, number of independent key channels (1..16).
REQ-002 Parameter DEBOUNCE_CYC, 500000, cycles a raw level must hold stable before acceptance.
REQ-003 Parameter LONG_CYC, 50000000, debounced hold cycles that classify a press as long.
REQ-004 Parameter GAP_CYC, 15000000, max debounced release-to-press cycles for a double click.
REQ-005 Parameter REPEAT_CYC, 10000000, long-press auto-repeat period; used only with REPEAT_EN.
REQ-006 CLOCK  input  1  single system clock, all logic on its rising edge.
REQ-007 RST  input  1  synchronous reset, active-high.
REQ-008 KEY  input  KEY_NUM  raw asynchronous keys, active-low (0 = pressed).
REQ-009 KEY_LVL  output  KEY_NUM  debounced key state, 1 = pressed.
REQ-010 SCLICK  output  KEY_NUM  one-cycle single-click pulse per channel.
REQ-011 LCLICK  output  KEY_NUM  one-cycle long-press pulse per channel.
REQ-012 DCLICK  output  KEY_NUM  one-cycle double-click pulse per channel.

Function
REQ-013 Each KEY bit SHALL pass a 2-flop synchroniser; channels SHALL be fully independent.
REQ-014 KEY_LVL[i] SHALL toggle only after the synchronised level differs from it for DEBOUNCE_CYC consecutive cycles; any agreement resets that channel's debounce counter.
REQ-015 Per-channel FSM states SHALL be IDLE, PRESS1, WAIT2, PRESS2, LONG; all timing counts use KEY_LVL, not raw input.
REQ-016 IDLE: KEY_LVL rise -> PRESS1, hold counter cleared.
REQ-017 PRESS1: KEY_LVL fall before LONG_CYC hold cycles -> WAIT2, gap counter cleared; hold reaching LONG_CYC -> LONG with one LCLICK pulse.
REQ-018 WAIT2: KEY_LVL rise before GAP_CYC cycles -> PRESS2 with one DCLICK pulse; gap counter reaching GAP_CYC -> IDLE with one SCLICK pulse.
REQ-019 PRESS2: KEY_LVL fall -> IDLE; hold duration ignored, no further pulse.
REQ-020 LONG: KEY_LVL fall -> IDLE, no pulse.
REQ-021 SCLICK/LCLICK/DCLICK SHALL be registered, exactly one cycle wide, and mutually exclusive per channel per cycle.
REQ-022 Pulse latency SHALL be exactly one cycle after the qualifying counter terminal cycle or KEY_LVL edge.
REQ-023 Counters SHALL be $clog2-sized to their parameter, saturate, and never wrap.
REQ-024 Events on different channels in the same cycle SHALL all be reported in that cycle.

Reset
REQ-025 RST high at a rising edge SHALL clear all synchronisers, counters and KEY_LVL to 0, all FSMs to IDLE, all pulse outputs to 0 on the next cycle.
REQ-026 RST mid-press SHALL discard the gesture; a still-held key SHALL be re-debounced and treated as a new press after RST falls.

Configuration
REQ-027 With REPEAT_EN defined, LONG SHALL emit an additional LCLICK pulse every REPEAT_CYC held cycles after entry until release.
REQ-028 Without REPEAT_EN, LONG SHALL emit no further pulses and the repeat counter SHALL not exist.

Verification (KEY_NUM=4, DEBOUNCE_CYC=4, LONG_CYC=20, GAP_CYC=10, REPEAT_CYC=8)
REQ-029 KEY[0] low 10 cycles, then high -> one SCLICK[0] pulse exactly 11 cycles after KEY_LVL[0] falls; no LCLICK/DCLICK.
REQ-030 KEY[1] glitch low 3 cycles -> KEY_LVL[1] stays 0, no pulses on any output.
REQ-031 KEY[2] low 8, high 6, low 8 cycles -> one DCLICK[2] pulse one cycle after second KEY_LVL rise; no SCLICK[2].
REQ-032 KEY[3] low 40 cycles -> one LCLICK[3] one cycle after hold counter reaches 20; with REPEAT_EN, second LCLICK 8 cycles later, third 8 after that.
REQ-033 KEY[0] and KEY[3] released together after short presses -> SCLICK[0] and SCLICK[3] asserted in the same cycle.
REQ-034 RST asserted 5 cycles into PRESS1 on KEY[1], key held -> all outputs 0; after RST falls, KEY_LVL[1] rises after debounce and LCLICK[1] follows a full LONG_CYC later.
